mac_seq_engine: RTL and testbench



---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_addr_gen.sv | 42 ++++
 rtl/mac_seq_engine.sv | 106 ++++++++++
 tb/tb_mac_seq_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencing engine.
package mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Sign-extend the low w bits of v to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
        logic [63:0] t;
        t = v << (64 - w);
        return 64'($signed(t) >>> (64 - w));
    endfunction

endpackage

// File: rtl/mac_addr_gen.sv
// Operand read-address counter: loads a job length, steps the index and flags the last address.
module mac_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            len_q <= '0;
        end else begin
            idx_q <= idx_d;
            len_q <= len_d;
        end
    end

    always_comb begin
        idx_d = idx_q;
        len_d = len_q;
        if (load_i) begin
            len_d = len_i;
            idx_d = '0;
        end else if (en_i) begin
            idx_d = idx_q + ADDR_W'(1);
        end
    end

    assign idx_o  = idx_q;
    // len_q is never 0 while enabled, so len_q-1 cannot wrap in use.
    assign last_o = (idx_q == (len_q - ADDR_W'(1)));

endmodule

// File: rtl/mac_seq_engine.sv
// Control/address stage of the MAC datapath: walks operand addresses, accumulates
// the returned products and hands the sum downstream over valid/ready.
module mac_seq_engine
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ACC_W  = ACC_W_DEF   // keep >= 2*DATA_W+ADDR_W and <= 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        len,
    output logic                     busy,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic [ACC_W-1:0]         result,
    output logic                     res_valid,
    input  logic                     res_ready
);

    state_e                   state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic                     rd_pipe_q;
    logic                     load;
    logic                     run_en;
    logic                     last;
    logic [ADDR_W-1:0]        idx;
    logic signed [2*DATA_W-1:0] prod;

    mac_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .len_i  (len),
        .en_i   (run_en),
        .idx_o  (idx),
        .last_o (last)
    );

    assign prod = a_in * b_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            rd_pipe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            rd_pipe_q <= mem_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Operands arrive one cycle after the strobe; rd_pipe_q is never set in IDLE,
        // so this never collides with the clear on start.
        if (rd_pipe_q) begin
            acc_d = acc_q + ACC_W'(sext(64'($unsigned(prod)), 2 * DATA_W));
        end
    end

    assign run_en    = (state_q == RUN);
    assign mem_rd    = run_en;
    assign mem_addr  = mem_rd ? idx : '0;
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign result    = acc_q;

endmodule

// File: tb/tb_mac_seq_engine.sv
// Directed bench for mac_seq_engine with a synchronous-read operand memory model.
module tb_mac_seq_engine;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        len;
    logic              busy;
    logic              mem_rd;
    logic [7:0]        mem_addr;
    logic signed [7:0] a_in;
    logic signed [7:0] b_in;
    logic [23:0]       result;
    logic              res_valid;
    logic              res_ready;

    logic signed [7:0] mem_a [0:255];
    logic signed [7:0] mem_b [0:255];

    int n_tests;
    int n_fail;
    int exp_addr;
    int rd_count;
    int hs_count;
    int lat;

    mac_seq_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .a_in      (a_in),
        .b_in      (b_in),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            a_in <= mem_a[mem_addr];
            b_in <= mem_b[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Address order and the zero-address rule are checked on every live cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                check("mem_addr_seq", 64'(mem_addr), 64'(exp_addr));
                exp_addr++;
                rd_count++;
            end else begin
                check("mem_addr_idle", 64'(mem_addr), 64'd0);
            end
            if (res_valid && res_ready) hs_count++;
        end
    end

    // Caller is #1 after an edge with the block in IDLE; returns #1 after the first valid edge.
    task automatic do_job(input int n, output int l);
        start    = 1'b1;
        len      = 8'(n);
        exp_addr = 0;
        rd_count = 0;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!res_valid && l < 600) begin
            @(posedge clk); #1;
            l++;
        end
        $display("[TB] job len=%0d latency=%0d result=0x%0h", n, l, result);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_addr  = 0;
        rd_count  = 0;
        hs_count  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'sd0;
            mem_b[i] = 8'sd0;
        end

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job: 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 8'(i + 1);
            mem_b[i] = 8'(i + 5);
        end
        do_job(4, lat);
        check("basic_latency", 64'(lat), 64'd6);
        check("basic_result", 64'(result), 64'd70);
        check("basic_rd_count", 64'(rd_count), 64'd4);
        @(posedge clk); #1;
        check("basic_valid_drop", 64'(res_valid), 64'd0);
        check("basic_idle", 64'(busy), 64'd0);
        check("basic_result_hold", 64'(result), 64'd70);
        $display("[TB] basic job done");

        // Signed extremes: 3 * 16384 = 49152
        for (int i = 0; i < 3; i++) begin
            mem_a[i] = -8'sd128;
            mem_b[i] = -8'sd128;
        end
        do_job(3, lat);
        check("neg_neg_result", 64'(result), 64'd49152);
        check("neg_neg_latency", 64'(lat), 64'd5);
        @(posedge clk); #1;
        // 3 * (-16256) = -48768
        for (int i = 0; i < 3; i++) mem_b[i] = 8'sd127;
        do_job(3, lat);
        check("neg_pos_result", 64'(result), 64'hFF4180);
        @(posedge clk); #1;

        // Zero length: straight to DONE, no reads
        do_job(0, lat);
        check("zero_latency", 64'(lat), 64'd1);
        check("zero_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        check("zero_rd_count", 64'(rd_count), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);

        // Backpressure with start held high through RUN, DONE and the handshake cycle: 3*2+4*5 = 26
        mem_a[0] = 8'sd3; mem_b[0] = 8'sd2;
        mem_a[1] = 8'sd4; mem_b[1] = 8'sd5;
        res_ready = 1'b0;
        start     = 1'b1;
        len       = 8'd2;
        exp_addr  = 0;
        rd_count  = 0;
        @(posedge clk); #1;
        len = 8'd7;
        lat = 1;
        while (!res_valid && lat < 600) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd4);
        hs_count = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_result_hold", 64'(result), 64'd26);
            check("bp_valid_hold", 64'(res_valid), 64'd1);
            check("bp_busy", 64'(busy), 64'd1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bp_valid_drop", 64'(res_valid), 64'd0);
        check("bp_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("bp_stays_idle", 64'(busy), 64'd0);
        check("bp_rd_count", 64'(rd_count), 64'd2);
        check("bp_handshakes", 64'(hs_count), 64'd1);
        $display("[TB] backpressure job done result=0x%0h", result);

        // Reset in the middle of a len=10 job
        for (int i = 0; i < 10; i++) begin
            mem_a[i] = 8'sd1;
            mem_b[i] = 8'sd1;
        end
        start    = 1'b1;
        len      = 8'd10;
        exp_addr = 0;
        rd_count = 0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("midrun_addr", 64'(mem_addr), 64'd5);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_mem_rd", 64'(mem_rd), 64'd0);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_valid", 64'(res_valid), 64'd0);
        check("midrun_rst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        $display("[TB] mid-run reset applied");

        // 7 * -3 = -21
        mem_a[0] = 8'sd7;
        mem_b[0] = -8'sd3;
        do_job(1, lat);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("post_rst_result", 64'(result), 64'hFFFFEB);
        @(posedge clk); #1;
        check("post_rst_valid_drop", 64'(res_valid), 64'd0);

        // Back-to-back: start in the first IDLE cycle, 2*9 = 18 with no residue
        mem_a[0] = 8'sd2;
        mem_b[0] = 8'sd9;
        do_job(1, lat);
        check("b2b_latency", 64'(lat), 64'd3);
        check("b2b_result", 64'(result), 64'd18);
        @(posedge clk); #1;
        check("b2b_idle", 64'(busy), 64'd0);
        check("b2b_rd_count", 64'(rd_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
